// File: rtl/remap_accel_hls_dl_pkg.sv
// Shared definitions for the HLS dataflow deadlock report controller:
// FSM encoding, counter widths and small helpers.
package remap_accel_hls_dl_pkg;

   localparam int unsigned DL_COUNT_W     = 8;
   localparam int unsigned DL_TRACE_CNT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ORIGIN = 3'd1,
      ST_TRACE  = 3'd2,
      ST_CLEAR  = 3'd3,
      ST_REPORT = 3'd4
   } dl_state_e;

   // Index width for a vector of n processes, never narrower than one bit
   function automatic int unsigned dl_id_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [DL_COUNT_W-1:0] dl_sat_inc(input logic [DL_COUNT_W-1:0] v);
      return (&v) ? v : v + DL_COUNT_W'(1);
   endfunction

endpackage

// File: rtl/remap_accel_hls_dl_prio_enc.sv
// Lowest-index priority encoder: returns the index of the lowest set bit
// and a flag telling whether any bit is set.
module remap_accel_hls_dl_prio_enc #(
   parameter int unsigned N    = 4,
   parameter int unsigned ID_W = 2
) (
   input  logic [N-1:0]    i_vec,
   output logic [ID_W-1:0] o_idx_c,
   output logic            o_any_c
);

   // Scan from the top so the lowest set bit is the last to win
   always_comb begin
      o_idx_c = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (i_vec[i]) o_idx_c = ID_W'(i);
      end
   end

   assign o_any_c = |i_vec;

endmodule

// File: rtl/remap_accel_hls_deadlock_report_ctrl.sv
// Deadlock report controller: picks an originating process, injects a token,
// traces which processes report detection until the token returns or a
// cycle limit expires, then holds a report until the host acknowledges.
module remap_accel_hls_deadlock_report_ctrl
   import remap_accel_hls_dl_pkg::*;
#(
   parameter int unsigned PROC_NUM  = 4,
   parameter int unsigned TRACE_MAX = 256
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             dl_en,
   input  logic [PROC_NUM-1:0]              dl_detect_vec,
   input  logic                             dl_ack,
   output logic                             dl_detect_in,
   output logic [PROC_NUM-1:0]              origin,
   output logic                             token_clear,
   output logic                             dl_valid,
   output logic [dl_id_w(PROC_NUM)-1:0]     dl_proc_id,
   output logic [PROC_NUM-1:0]              dl_path,
   output logic                             dl_timeout,
   output logic [DL_COUNT_W-1:0]            dl_count
);

   localparam int unsigned ID_W = dl_id_w(PROC_NUM);

   dl_state_e                 r_state;
   logic [ID_W-1:0]           r_owner;
   logic [DL_TRACE_CNT_W-1:0] r_cnt;
   logic [PROC_NUM-1:0]       r_path;
   logic [PROC_NUM-1:0]       r_origin;
   logic                      r_detect_in;
   logic                      r_token_clear;
   logic                      r_valid;
   logic                      r_timeout;
   logic [DL_COUNT_W-1:0]     r_count;

   logic [ID_W-1:0]           w_idx;
   logic                      w_any;
   logic [PROC_NUM-1:0]       w_idx_oh;

   remap_accel_hls_dl_prio_enc #(
      .N    (PROC_NUM),
      .ID_W (ID_W)
   ) u_prio_enc (
      .i_vec   (dl_detect_vec),
      .o_idx_c (w_idx),
      .o_any_c (w_any)
   );

   assign w_idx_oh = PROC_NUM'(1) << w_idx;

   // State and every output register update together, so outputs follow state exactly
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_owner       <= '0;
         r_cnt         <= '0;
         r_path        <= '0;
         r_origin      <= '0;
         r_detect_in   <= 1'b0;
         r_token_clear <= 1'b0;
         r_valid       <= 1'b0;
         r_timeout     <= 1'b0;
         r_count       <= '0;
      end else begin
         r_origin      <= '0;
         r_token_clear <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (dl_en && w_any) begin
                  r_state     <= ST_ORIGIN;
                  r_owner     <= w_idx;
                  r_path      <= w_idx_oh;
                  r_timeout   <= 1'b0;
                  r_cnt       <= '0;
                  r_origin    <= w_idx_oh;
                  r_detect_in <= 1'b1;
               end
            end
            ST_ORIGIN: begin
               r_cnt <= '0;
               if (!dl_en) begin
                  r_state     <= ST_IDLE;
                  r_detect_in <= 1'b0;
               end else begin
                  r_state <= ST_TRACE;
               end
            end
            ST_TRACE: begin
               if (!dl_en) begin
                  r_state     <= ST_IDLE;
                  r_detect_in <= 1'b0;
               end else begin
                  r_path <= r_path | dl_detect_vec;
                  r_cnt  <= r_cnt + DL_TRACE_CNT_W'(1);
                  // Token return outranks the limit when both land on the same cycle
                  if (dl_detect_vec[r_owner]) begin
                     r_state       <= ST_CLEAR;
                     r_token_clear <= 1'b1;
                  end else if (r_cnt == DL_TRACE_CNT_W'(TRACE_MAX - 1)) begin
                     r_state   <= ST_REPORT;
                     r_timeout <= 1'b1;
                     r_valid   <= 1'b1;
                     r_count   <= dl_sat_inc(r_count);
                  end
               end
            end
            ST_CLEAR: begin
               r_state <= ST_REPORT;
               r_valid <= 1'b1;
               r_count <= dl_sat_inc(r_count);
            end
            ST_REPORT: begin
               if (dl_ack) begin
                  r_state     <= ST_IDLE;
                  r_valid     <= 1'b0;
                  r_detect_in <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_valid     <= 1'b0;
               r_detect_in <= 1'b0;
            end
         endcase
      end
   end

   assign dl_detect_in = r_detect_in;
   assign origin       = r_origin;
   assign token_clear  = r_token_clear;
   assign dl_valid     = r_valid;
   assign dl_proc_id   = r_owner;
   assign dl_path      = r_path;
   assign dl_timeout   = r_timeout;
   assign dl_count     = r_count;

endmodule

// File: tb/tb_remap_accel_hls_deadlock_report_ctrl.sv
// Directed bench for the deadlock report controller (PROC_NUM=4, TRACE_MAX=16);
// expected reports are queued at stimulus time and popped when dl_valid rises.
module tb_remap_accel_hls_deadlock_report_ctrl;

   localparam int unsigned PN = 4;
   localparam int unsigned TM = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          dl_en;
   logic [PN-1:0] dl_detect_vec;
   logic          dl_ack;
   logic          dl_detect_in;
   logic [PN-1:0] origin;
   logic          token_clear;
   logic          dl_valid;
   logic [1:0]    dl_proc_id;
   logic [PN-1:0] dl_path;
   logic          dl_timeout;
   logic [7:0]    dl_count;

   typedef struct {
      logic [1:0]    id;
      logic [PN-1:0] path;
      logic          timeout;
      logic [7:0]    count;
   } rpt_t;

   rpt_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   remap_accel_hls_deadlock_report_ctrl #(
      .PROC_NUM  (PN),
      .TRACE_MAX (TM)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .dl_en         (dl_en),
      .dl_detect_vec (dl_detect_vec),
      .dl_ack        (dl_ack),
      .dl_detect_in  (dl_detect_in),
      .origin        (origin),
      .token_clear   (token_clear),
      .dl_valid      (dl_valid),
      .dl_proc_id    (dl_proc_id),
      .dl_path       (dl_path),
      .dl_timeout    (dl_timeout),
      .dl_count      (dl_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_quiet(input string tag, input logic [7:0] cnt);
      chk({tag, "_detect_in"}, 32'(dl_detect_in), 32'd0);
      chk({tag, "_origin"},    32'(origin),       32'd0);
      chk({tag, "_tclear"},    32'(token_clear),  32'd0);
      chk({tag, "_valid"},     32'(dl_valid),     32'd0);
      chk({tag, "_count"},     32'(dl_count),     32'(cnt));
   endtask

   // Bounded wait for dl_valid, compare against the oldest queued report, then acknowledge
   task automatic wait_report(input string tag, input int maxc, input int hold,
                              output bit saw_clear, output int ncyc);
      rpt_t e;
      saw_clear = 1'b0;
      ncyc      = 0;
      while (dl_valid !== 1'b1 && ncyc < maxc) begin
         if (token_clear === 1'b1) saw_clear = 1'b1;
         step();
         ncyc++;
      end
      if (dl_valid !== 1'b1) begin
         chk({tag, "_report_wait"}, 32'(dl_valid), 32'd1);
         return;
      end
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() == 0) return;
      e = exp_q.pop_front();
      for (int h = 0; h <= hold; h++) begin
         chk({tag, "_proc_id"},   32'(dl_proc_id),   32'(e.id));
         chk({tag, "_path"},      32'(dl_path),      32'(e.path));
         chk({tag, "_timeout"},   32'(dl_timeout),   32'(e.timeout));
         chk({tag, "_count"},     32'(dl_count),     32'(e.count));
         chk({tag, "_detect_in"}, 32'(dl_detect_in), 32'd1);
         if (h < hold) step();
      end
      dl_ack = 1'b1;
      step();
      chk({tag, "_ack_valid"},     32'(dl_valid),     32'd0);
      chk({tag, "_ack_detect_in"}, 32'(dl_detect_in), 32'd0);
      dl_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit sc;
      int nc;

      reset = 1'b0; dl_en = 1'b0; dl_detect_vec = '0; dl_ack = 1'b0;
      step(); step();
      chk_quiet("reset", 8'd0);
      chk("reset_path",    32'(dl_path),    32'd0);
      chk("reset_id",      32'(dl_proc_id), 32'd0);
      chk("reset_timeout", 32'(dl_timeout), 32'd0);
      reset = 1'b1;
      step();

      // Owner 2, bit1 joins the path, token back after four trace cycles
      dl_en = 1'b1; dl_detect_vec = 4'b0100;
      exp_q.push_back('{id: 2'd2, path: 4'b0110, timeout: 1'b0, count: 8'd1});
      step();                                   // cycle 1
      chk("s1_origin",    32'(origin),       32'h4);
      chk("s1_detect_in", 32'(dl_detect_in), 32'd1);
      dl_detect_vec = 4'b0000;
      step();                                   // cycle 2
      chk("s1_origin_one_cycle", 32'(origin), 32'd0);
      step();                                   // cycle 3
      dl_detect_vec = 4'b0010;
      step();                                   // cycle 4
      dl_detect_vec = 4'b0000;
      step();                                   // cycle 5
      dl_detect_vec = 4'b0100;
      step();                                   // cycle 6
      dl_detect_vec = 4'b0000;
      chk("s1_tclear", 32'(token_clear), 32'd1);
      chk("s1_valid6", 32'(dl_valid),    32'd0);
      wait_report("s1", 4, 2, sc, nc);
      chk("s1_latency", 32'(nc), 32'd1);

      // Two requesters: lowest index wins
      dl_detect_vec = 4'b1010;
      exp_q.push_back('{id: 2'd1, path: 4'b0010, timeout: 1'b0, count: 8'd2});
      step();
      chk("s2_origin", 32'(origin),     32'h2);
      chk("s2_id",     32'(dl_proc_id), 32'd1);
      dl_detect_vec = 4'b0000;
      step();
      dl_detect_vec = 4'b0010;
      step();
      dl_detect_vec = 4'b0000;
      chk("s2_tclear", 32'(token_clear), 32'd1);
      wait_report("s2", 4, 0, sc, nc);
      chk("s2_latency", 32'(nc), 32'd1);

      // No return: timeout after 16 trace cycles, no clear pulse
      dl_detect_vec = 4'b0001;
      exp_q.push_back('{id: 2'd0, path: 4'b0001, timeout: 1'b1, count: 8'd3});
      step();
      chk("s3_origin", 32'(origin), 32'h1);
      dl_detect_vec = 4'b0000;
      wait_report("s3", 40, 0, sc, nc);
      chk("s3_latency",  32'(nc), 32'd17);
      chk("s3_no_clear", 32'(sc), 32'd0);

      // Return on the last trace cycle resolves as a token return
      dl_detect_vec = 4'b1000;
      exp_q.push_back('{id: 2'd3, path: 4'b1000, timeout: 1'b0, count: 8'd4});
      step();
      chk("s4_origin", 32'(origin), 32'h8);
      dl_detect_vec = 4'b0000;
      repeat (16) step();                       // cycle 17
      dl_detect_vec = 4'b1000;
      step();                                   // cycle 18
      dl_detect_vec = 4'b0000;
      chk("s4_tclear", 32'(token_clear), 32'd1);
      chk("s4_valid",  32'(dl_valid),    32'd0);
      wait_report("s4", 4, 0, sc, nc);
      chk("s4_latency", 32'(nc), 32'd1);

      // Enable drop mid-trace aborts without a report; ack in trace is ignored
      dl_detect_vec = 4'b0010;
      step();
      dl_detect_vec = 4'b0000;
      step();
      dl_ack = 1'b1;
      step();
      dl_ack = 1'b0;
      chk("s5_still_trace", 32'(dl_detect_in), 32'd1);
      chk("s5_no_valid",    32'(dl_valid),     32'd0);
      dl_en = 1'b0;
      step();
      chk_quiet("s5_abort", 8'd4);
      dl_en = 1'b1;
      step();
      chk("s5_idle", 32'(dl_detect_in), 32'd0);

      // Reset in the middle of a trace
      dl_detect_vec = 4'b0100;
      step();
      dl_detect_vec = 4'b0000;
      step(); step();
      reset = 1'b0;
      step();
      chk_quiet("s6_reset", 8'd0);
      chk("s6_path", 32'(dl_path), 32'd0);
      reset = 1'b1;
      step();
      chk("s6_idle", 32'(dl_detect_in), 32'd0);

      // Back-to-back persistent detection saturates the report counter
      dl_detect_vec = 4'b0001;
      for (int k = 1; k <= 256; k++) begin
         exp_q.push_back('{id: 2'd0, path: 4'b0001, timeout: 1'b0,
                           count: (k > 255) ? 8'd255 : 8'(k)});
         wait_report("sat", 10, 0, sc, nc);
      end
      dl_detect_vec = 4'b0000;
      dl_ack = 1'b1;
      step();
      step();
      dl_ack = 1'b0;
      chk_quiet("s7_ack_idle", 8'd255);

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/remap_accel_hls_deadlock_report_ctrl.md
REMAP_ACCEL_HLS_DEADLOCK_REPORT_CTRL -- requirements
Module: remap_accel_hls_deadlock_report_ctrl

Interface
REQ-001 SHALL have parameter PROC_NUM, default 4: number of dataflow processes/detect units served.
REQ-002 SHALL have parameter TRACE_MAX, default 256: TRACE-state cycle limit before timeout report; legal range 2..65535.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 SHALL have port dl_en  input  1  arms detection; low aborts an in-progress trace.
REQ-006 SHALL have port dl_detect_vec  input  PROC_NUM  dl_detect_out of each detect unit, bit i = process i.
REQ-007 SHALL have port dl_ack  input  1  host acknowledge of a pending report.
REQ-008 SHALL have port dl_detect_in  output  1  broadcast to all detect units; freezes dependence state during trace/report.
REQ-009 SHALL have port origin  output  PROC_NUM  one-hot token-injection pulse, bit i to unit i.
REQ-010 SHALL have port token_clear  output  1  broadcast one-cycle token kill pulse.
REQ-011 SHALL have port dl_valid  output  1  report pending.
REQ-012 SHALL have port dl_proc_id  output  $clog2(PROC_NUM) (min 1)  index of originating process.
REQ-013 SHALL have port dl_path  output  PROC_NUM  bitmap of processes seen asserting dl_detect_vec during trace.
REQ-014 SHALL have port dl_timeout  output  1  report ended by TRACE_MAX, not by token return.
REQ-015 SHALL have port dl_count  output  8  saturating count of reports issued since reset.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, ORIGIN, TRACE, CLEAR, REPORT; all outputs decoded from registered state/data only.
REQ-017 IDLE: all control outputs 0; if dl_en=1 and |dl_detect_vec, SHALL latch owner = lowest set index, dl_path = one-hot(owner), go ORIGIN.
REQ-018 ORIGIN: exactly one cycle; dl_detect_in=1, origin=one-hot(owner), trace counter cleared to 0; next state TRACE.
REQ-019 TRACE: dl_detect_in=1, origin=0; each cycle dl_path |= dl_detect_vec and counter +1 (16-bit, no wrap reachable).
REQ-020 TRACE exit: dl_detect_vec[owner]=1 -> CLEAR with dl_timeout=0; else counter==TRACE_MAX-1 -> REPORT with dl_timeout=1, no CLEAR pulse.
REQ-021 Simultaneous token return and counter limit SHALL resolve as token return (CLEAR, dl_timeout=0).
REQ-022 CLEAR: exactly one cycle; token_clear=1, dl_detect_in=1; next state REPORT.
REQ-023 REPORT: dl_valid=1, dl_detect_in=1; dl_proc_id/dl_path/dl_timeout held stable; dl_count increments by 1 on entry, saturating at 255.
REQ-024 REPORT exit: dl_ack=1 -> IDLE next cycle; dl_ack in any other state SHALL be ignored.
REQ-025 dl_en=0 in ORIGIN or TRACE SHALL return FSM to IDLE next cycle, no report, dl_count unchanged; dl_en has no effect in CLEAR or REPORT.
REQ-026 Latency: detect sampled cycle N -> origin pulse cycle N+1 -> TRACE from N+2; token return sampled cycle M -> token_clear M+1 -> dl_valid M+2.
REQ-027 After ack, re-detection SHALL be permitted from IDLE on the next cycle (persisting deadlock re-reports).

Reset
REQ-028 reset=0 at a clock edge SHALL force IDLE, owner=0, counter=0, dl_path=0, dl_timeout=0, dl_count=0, all outputs 0, from any state including mid-TRACE.
REQ-029 No output SHALL change asynchronously to clock.

Structure
REQ-030 Shared package remap_accel_hls_dl_pkg SHALL hold the FSM state encoding, the dl_count width (8) and the trace counter width (16).
REQ-031 Lowest-index selection SHALL be a sub-module remap_accel_hls_dl_prio_enc (PROC_NUM-bit vector -> index + any flag).

Verification (PROC_NUM=4, TRACE_MAX=16)
REQ-032 dl_en=1, dl_detect_vec=4'b0100 at cycle 0, token returns (bit2) at cycle 5 with bit1 pulsed at cycle 3 -> origin=4'b0100 in cycle 1, token_clear in cycle 6, dl_valid cycle 7, dl_proc_id=2, dl_path=4'b0110, dl_timeout=0, dl_count=1.
REQ-033 dl_detect_vec=4'b1010 in IDLE -> owner=1, origin=4'b0010.
REQ-034 Detect at bit0, no return -> REPORT after 16 TRACE cycles, dl_timeout=1, token_clear never asserted.
REQ-035 Owner bit returns on 16th TRACE cycle -> CLEAR then REPORT with dl_timeout=0.
REQ-036 reset=0 mid-TRACE, and dl_en=0 mid-TRACE -> IDLE next cycle, dl_detect_in=0, dl_count unchanged (0 after reset).
REQ-037 256 consecutive detect/ack cycles -> dl_count saturates at 255; dl_ack outside REPORT has no effect.
